// File: rtl/vpe_tf_pkg.sv
// Shared definitions for the TFE address issuer and the VPE traffic-feature fetcher.
package vpe_tf_pkg;

   localparam int TF_ADDR_W = 12;

   typedef enum logic [1:0] {
      TF_IDLE   = 2'd0,
      TF_ARMED  = 2'd1,
      TF_STREAM = 2'd2
   } tf_state_e;

endpackage

// File: rtl/vpe_tf_addr_fifo.sv
// Synchronous address FIFO with registered read data, occupancy level and sticky overflow.
module vpe_tf_addr_fifo
   import vpe_tf_pkg::*;
#(
   parameter int ADDR_W = TF_ADDR_W,
   parameter int DEPTH  = 32,
   localparam int PW    = $clog2(DEPTH),
   localparam int LW    = PW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wr_data,
   input  logic              wr_v,
   input  logic              rd_en,
   output logic [ADDR_W-1:0] rd_data,
   output logic              rd_v,
   output logic [LW-1:0]     level,
   output logic              full,
   output logic              empty,
   output logic              ovf
);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wp, rp;
   logic              push, pop;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);
   assign push  = wr_v && !full;
   assign pop   = rd_en && !empty;

   // Storage carries no reset; validity is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         level   <= '0;
         rd_data <= '0;
         rd_v    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) begin
            rd_data <= mem[rp];
            rp      <= rp + 1'b1;
         end
         rd_v <= pop;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (wr_v && full) ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/vpe_tf_addr_issuer.sv
// Buffers TFE feature addresses and streams one VEC_LEN burst per fetcher request.
module vpe_tf_addr_issuer
   import vpe_tf_pkg::*;
#(
   parameter int ADDR_W  = TF_ADDR_W,
   parameter int VEC_LEN = 8,
   parameter int DEPTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic                   wr_v,
   output logic                   wr_full,
   output logic                   rdy_for_fetch,
   input  logic                   rd_fifo_en,
   output logic [ADDR_W-1:0]      o_fea_addr,
   output logic                   o_fea_addr_v,
   output logic [$clog2(DEPTH):0] level,
   output logic                   err_ovf,
   output logic                   err_proto
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(VEC_LEN + 1);

   tf_state_e     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pop, proto_hit, fifo_empty;

   vpe_tf_addr_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (wr_addr),
      .wr_v    (wr_v),
      .rd_en   (pop && !fifo_empty),
      .rd_data (o_fea_addr),
      .rd_v    (o_fea_addr_v),
      .level   (level),
      .full    (wr_full),
      .empty   (fifo_empty),
      .ovf     (err_ovf)
   );

   // The first pop happens on the accepting edge so data is valid the next
   // cycle; STREAM then spans exactly the VEC_LEN valid-output cycles, which
   // forces the one-cycle IDLE gap before re-arming.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      proto_hit = 1'b0;
      case (state)
         TF_IDLE: begin
            proto_hit = rd_fifo_en;
            if (level >= LW'(VEC_LEN)) state_nxt = TF_ARMED;
         end
         TF_ARMED: begin
            if (rd_fifo_en) begin
               pop       = 1'b1;
               cnt_nxt   = '0;
               state_nxt = TF_STREAM;
            end
         end
         TF_STREAM: begin
            proto_hit = rd_fifo_en;
            if (cnt == CW'(VEC_LEN - 1)) begin
               state_nxt = TF_IDLE;
            end else begin
               pop     = 1'b1;
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = TF_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= TF_IDLE;
         cnt           <= '0;
         rdy_for_fetch <= 1'b0;
         err_proto     <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         rdy_for_fetch <= (state_nxt == TF_ARMED);
         if (proto_hit) err_proto <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vpe_tf_addr_issuer.sv
// Directed bench for vpe_tf_addr_issuer with an in-order address scoreboard.
module tb_vpe_tf_addr_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] wr_addr;
   logic        wr_v;
   logic        wr_full;
   logic        rdy_for_fetch;
   logic        rd_fifo_en;
   logic [11:0] o_fea_addr;
   logic        o_fea_addr_v;
   logic [5:0]  level;
   logic        err_ovf;
   logic        err_proto;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q[$];

   vpe_tf_addr_issuer #(.ADDR_W(12), .VEC_LEN(8), .DEPTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_addr       (wr_addr),
      .wr_v          (wr_v),
      .wr_full       (wr_full),
      .rdy_for_fetch (rdy_for_fetch),
      .rd_fifo_en    (rd_fifo_en),
      .o_fea_addr    (o_fea_addr),
      .o_fea_addr_v  (o_fea_addr_v),
      .level         (level),
      .err_ovf       (err_ovf),
      .err_proto     (err_proto)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every valid output beat must match the oldest accepted address.
   always @(negedge clk) begin
      if (o_fea_addr_v === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL stream_extra: observed %0h expected no output", o_fea_addr);
         end else begin
            check("stream_data", {20'd0, o_fea_addr}, {20'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [11:0] a, input bit accepted);
      wr_v    = 1'b1;
      wr_addr = a;
      if (accepted) exp_q.push_back(a);
   endtask

   task automatic push_n(input logic [11:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         drive_push(base + 12'(i), 1'b1);
         tick;
      end
      wr_v = 1'b0;
   endtask

   task automatic wait_rdy;
      int n = 0;
      while (rdy_for_fetch !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
      check("wait_rdy", {31'd0, rdy_for_fetch}, 32'd1);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      wr_v = 1'b0;
      rd_fifo_en = 1'b0;
      tick;
      exp_q.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_rdy"},   {31'd0, rdy_for_fetch}, 32'd0);
      check({tag, "_v"},     {31'd0, o_fea_addr_v}, 32'd0);
      check({tag, "_addr"},  {20'd0, o_fea_addr}, 32'd0);
      check({tag, "_level"}, {26'd0, level}, 32'd0);
      check({tag, "_full"},  {31'd0, wr_full}, 32'd0);
      check({tag, "_ovf"},   {31'd0, err_ovf}, 32'd0);
      check({tag, "_proto"}, {31'd0, err_proto}, 32'd0);
   endtask

   // One burst from ARMED: optional extra rd_fifo_en at stream beat mid_k,
   // optional continuous pushes starting at push_base on the request edge.
   task automatic burst(input bit rearm, input int mid_k, input bit do_push, input logic [11:0] push_base);
      int vc = 0;
      rd_fifo_en = 1'b1;
      if (do_push) drive_push(push_base, 1'b1);
      tick;
      rd_fifo_en = 1'b0;
      check("burst_rdy_low", {31'd0, rdy_for_fetch}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         if (o_fea_addr_v === 1'b1) vc++;
         if (do_push) check("burst_level_flat", {26'd0, level}, 32'd8);
         rd_fifo_en = (k == mid_k);
         if (do_push && k < 7) drive_push(push_base + 12'(k + 1), 1'b1);
         else wr_v = 1'b0;
         tick;
      end
      rd_fifo_en = 1'b0;
      wr_v = 1'b0;
      check("burst_len", vc, 8);
      check("burst_end_v", {31'd0, o_fea_addr_v}, 32'd0);
      check("idle_gap", {31'd0, rdy_for_fetch}, 32'd0);
      tick;
      check("rearm", {31'd0, rdy_for_fetch}, {31'd0, rearm});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int vc;
      rst = 1'b1;
      wr_v = 1'b0;
      wr_addr = '0;
      rd_fifo_en = 1'b0;
      tick;
      tick;
      check_reset_state("reset");
      rst = 1'b0;

      // basic vector
      push_n(12'h010, 8);
      check("lvl_after_8", {26'd0, level}, 32'd8);
      check("rdy_not_yet", {31'd0, rdy_for_fetch}, 32'd0);
      tick;
      check("rdy_rise", {31'd0, rdy_for_fetch}, 32'd1);
      burst(1'b0, -1, 1'b0, 12'h0);
      check("lvl_after_burst", {26'd0, level}, 32'd0);
      check("proto_clean", {31'd0, err_proto}, 32'd0);

      // short vector never arms; early request is a protocol error
      push_n(12'h100, 7);
      tick;
      tick;
      check("short_no_rdy", {31'd0, rdy_for_fetch}, 32'd0);
      rd_fifo_en = 1'b1;
      tick;
      rd_fifo_en = 1'b0;
      vc = 0;
      for (int k = 0; k < 10; k++) begin
         if (o_fea_addr_v === 1'b1) vc++;
         tick;
      end
      check("short_no_out", vc, 0);
      check("short_proto", {31'd0, err_proto}, 32'd1);
      check("short_level", {26'd0, level}, 32'd7);
      push_n(12'h107, 1);
      tick;
      check("short_arm", {31'd0, rdy_for_fetch}, 32'd1);
      burst(1'b0, -1, 1'b0, 12'h0);

      // fill to full, overflow push dropped, four bursts drain in order
      push_n(12'h200, 32);
      check("full_level", {26'd0, level}, 32'd32);
      check("full_flag", {31'd0, wr_full}, 32'd1);
      check("ovf_before", {31'd0, err_ovf}, 32'd0);
      drive_push(12'hFFF, 1'b0);
      tick;
      wr_v = 1'b0;
      check("ovf_set", {31'd0, err_ovf}, 32'd1);
      check("ovf_level", {26'd0, level}, 32'd32);
      for (int b = 0; b < 4; b++) begin
         wait_rdy;
         burst(b < 3, -1, 1'b0, 12'h0);
      end
      check("drain_level", {26'd0, level}, 32'd0);
      check("ovf_sticky", {31'd0, err_ovf}, 32'd1);

      // push every cycle of a burst keeps level flat and re-arms at t+VEC_LEN+2
      push_n(12'h300, 8);
      wait_rdy;
      burst(1'b1, -1, 1'b1, 12'h310);
      burst(1'b0, -1, 1'b0, 12'h0);

      // reset clears sticky flags; second request mid-burst is ignored
      do_reset;
      check_reset_state("reset2");
      rst = 1'b0;
      push_n(12'h400, 8);
      wait_rdy;
      burst(1'b0, 3, 1'b0, 12'h0);
      check("mid_proto", {31'd0, err_proto}, 32'd1);
      check("mid_level", {26'd0, level}, 32'd0);

      // reset on the 4th streamed beat aborts the burst
      push_n(12'h500, 16);
      wait_rdy;
      rd_fifo_en = 1'b1;
      tick;
      rd_fifo_en = 1'b0;
      tick;
      tick;
      tick;
      check("abort_v_before", {31'd0, o_fea_addr_v}, 32'd1);
      do_reset;
      check_reset_state("abort");
      rst = 1'b0;
      tick;
      check("abort_idle", {31'd0, rdy_for_fetch}, 32'd0);
      check("abort_no_v", {31'd0, o_fea_addr_v}, 32'd0);

      tick;
      check("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
